pc_unit_ras: RTL and testbench
==============================

# pc_unit_ras

Parametrised program-counter unit for the pipelined 16-bit core. It replaces the single-entry return register and the fixed next-PC mux with a configurable-width PC and a depth-N circular return-address stack. It resolves sequential, branch, jump, call, return and for-loop redirects issued by a later pipeline stage, and produces a one-cycle flush pulse for the front end. It sits between instruction memory (`pc_out` drives the fetch address) and the execute-stage control/condition logic.

## Interface
Parameters:
- `WIDTH`, 16: PC and data width.
- `RAS_DEPTH`, 4: return-stack entries, ≥2.
- `JMP_BITS`, 9: width of the absolute jump field.
- `OFF_BITS`, 6: width of the signed branch offset.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold the PC. Ignored when a redirect is taken.
- `cmd`  in  3: 0 SEQ, 1 BRANCH, 2 JMP, 3 CALL, 4 RET, 5 FOR. Codes 6–7 behave as SEQ.
- `take`  in  1: condition outcome. Used only by BRANCH and FOR.
- `cmd_pc`  in  WIDTH: PC of the instruction issuing `cmd`.
- `jmp_field`  in  JMP_BITS: absolute target bits for JMP/CALL.
- `offset`  in  OFF_BITS: two's-complement branch offset.
- `reg_target`  in  WIDTH: register-sourced loop target for FOR.
- `pc_out`  out  WIDTH: current fetch PC, registered.
- `pc_plus_1`  out  WIDTH: `pc_out`+1, combinational.
- `flush`  out  1: registered. High for one cycle after a taken redirect.
- `ras_top`  out  WIDTH: top-of-stack entry, or 0 when the stack is empty.
- `ras_count`  out  clog2(RAS_DEPTH+1): number of valid entries.
- `ras_overflow`  out  1: sticky. Set when a push occurs with the stack full.
- `ras_underflow`  out  1: sticky. Set when a pop occurs with the stack empty.

## Operation
Definitions:
- `cp1` = `cmd_pc`+1.
- `jt` = {`cp1`[WIDTH-1:JMP_BITS], `jmp_field`}.
- `bt` = `cmd_pc` + sign_extend(`offset`).

Redirect table (applies only when the condition holds):
- BRANCH, `take`=1: next PC = `bt`.
- JMP: next PC = `jt`.
- CALL: next PC = `jt`; push `cp1`.
- RET, stack non-empty: next PC = top entry; pop.
- RET, stack empty: next PC = `cp1`; count stays 0; set `ras_underflow`.
- FOR, `take`=1: next PC = `reg_target`.

Non-redirect cycles (SEQ, codes 6–7, BRANCH/FOR with `take`=0):
- `pc_out` <= `pc_out`+1 when `stall`=0.
- `pc_out` holds when `stall`=1.

Priority:
- A taken redirect overrides `stall`. The stack operation still happens.

Return-address stack:
- Circular buffer with a top pointer mod RAS_DEPTH.
- Push with count < RAS_DEPTH: increment pointer, write entry, increment count.
- Push with count = RAS_DEPTH: overwrite the oldest entry, which becomes the new top; count stays RAS_DEPTH; set `ras_overflow`.
- Pop: decrement pointer and count.
- At most one push or pop per cycle.

Arithmetic:
- All PC arithmetic is modulo 2^WIDTH. `pc_out`=16'hFFFF with SEQ gives 16'h0000.
- Offset sign-extension uses bit OFF_BITS-1.

Reset (synchronous):
- `pc_out`=RESET_PC.
- Stack entries and top pointer cleared; `ras_count`=0.
- `ras_top`=0, `flush`=0, both sticky flags cleared.
- A reset asserted mid-operation discards any in-flight `cmd` in that cycle.

## Timing
- `pc_out`, the stack, `ras_count`, the flags and `flush` update on the rising `clk` edge. `pc_plus_1` and `ras_top` are combinational from registers.
- A redirect presented in cycle N: `pc_out` = target in cycle N+1, and `flush`=1 in cycle N+1 only.
- Back-to-back redirects produce a `flush` pulse in each following cycle.
- A stack push or pop in cycle N is visible on `ras_top`/`ras_count` in cycle N+1.
- CALL then RET in consecutive cycles returns the address just pushed.
- No combinational path from inputs to outputs.

## Test plan
- **Reset and sequential advance:** release `rst`, cmd=SEQ for 3 cycles → `pc_out` 0,1,2,3; `flush`=0; `ras_count`=0. With `rst`=1 mid-run → `pc_out`=0 on the next edge.
- **Branch:** cmd_pc=16'h0010, offset=6'h3E, take=1 → `pc_out`=16'h000E and `flush`=1 next cycle. With take=0 and stall=1 → `pc_out` holds.
- **Call/return:** cmd_pc=16'h1234, jmp_field=9'h045, CALL → `pc_out`=16'h1245, `ras_top`=16'h1235, count=1. Then RET → `pc_out`=16'h1235, count=0.
- **Overflow wrap:** 5 CALLs with cmd_pc=10,20,30,40,50 (RAS_DEPTH=4) → `ras_overflow`=1, count=4. Four RETs return 51,41,31,21. A fifth RET sets `ras_underflow` and goes to `cmd_pc`+1.
- **For-loop and stall override:** stall=1, cmd=FOR, take=1, reg_target=16'h0100 → `pc_out`=16'h0100, `flush`=1. The same command with take=0 and stall=0 → `pc_out`+1.
- **Wrap-around:** `pc_out`=16'hFFFF, SEQ → `pc_out`=16'h0000.

Source files
------------

// File: rtl/pc_unit_ras.sv
// pc_unit_ras -- program-counter unit with a circular return-address stack.
//
// Purpose:
//   Holds the fetch PC for the pipelined core and applies redirects issued by a
//   later pipeline stage. The supported redirects are branch, jump, call, return
//   and for-loop. A depth-RAS_DEPTH circular stack keeps return addresses. A
//   one-cycle flush pulse follows every taken redirect.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall           hold the PC (ignored when a redirect is taken)
//   cmd, take       command (0 SEQ,1 BRANCH,2 JMP,3 CALL,4 RET,5 FOR) and condition
//   cmd_pc          PC of the instruction issuing cmd
//   jmp_field       absolute target bits for JMP/CALL
//   offset          signed branch offset
//   reg_target      register-sourced loop target for FOR
//   pc_out          registered fetch PC
//   pc_plus_1       pc_out + 1
//   flush           registered; high for one cycle after a taken redirect
//   ras_top         top-of-stack entry, 0 when empty
//   ras_count       number of valid stack entries
//   ras_overflow    sticky: push while full
//   ras_underflow   sticky: pop while empty
module pc_unit_ras #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4,
  parameter int JMP_BITS  = 9,
  parameter int OFF_BITS  = 6,
  parameter int RESET_PC  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [2:0]                       cmd,
  input  logic                             take,
  input  logic [WIDTH-1:0]                 cmd_pc,
  input  logic [JMP_BITS-1:0]              jmp_field,
  input  logic [OFF_BITS-1:0]              offset,
  input  logic [WIDTH-1:0]                 reg_target,
  output logic [WIDTH-1:0]                 pc_out,
  output logic [WIDTH-1:0]                 pc_plus_1,
  output logic                             flush,
  output logic [WIDTH-1:0]                 ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] CMD_BRANCH = 3'd1;
  localparam logic [2:0] CMD_JMP    = 3'd2;
  localparam logic [2:0] CMD_CALL   = 3'd3;
  localparam logic [2:0] CMD_RET    = 3'd4;
  localparam logic [2:0] CMD_FOR    = 3'd5;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Registered state
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];

  // Target computation
  logic [WIDTH-1:0] cp1;
  logic [WIDTH-1:0] jt;
  logic [WIDTH-1:0] bt;
  logic [WIDTH-1:0] top_entry;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             push;
  logic             pop;
  logic             stack_empty;
  logic             stack_full;
  logic [RAS_DEPTH-1:0] wr_sel;

  assign cp1 = cmd_pc + WIDTH'(1);
  // The jump keeps the page bits of the following instruction.
  assign jt  = {cp1[WIDTH-1:JMP_BITS], jmp_field};
  assign bt  = cmd_pc + {{(WIDTH-OFF_BITS){offset[OFF_BITS-1]}}, offset};

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CNT_FULL);
  assign top_entry   = stack_q[ptr_q];

  // Explicit wrap keeps the pointer correct for non-power-of-two depths.
  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);

  // Next-PC selection and stack control
  always_comb begin
    pc_d    = stall ? pc_q : pc_q + WIDTH'(1);
    flush_d = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unf_d   = unf_q;
    case (cmd)
      CMD_BRANCH: begin
        if (take) begin
          pc_d    = bt;
          flush_d = 1'b1;
        end
      end
      CMD_JMP: begin
        pc_d    = jt;
        flush_d = 1'b1;
      end
      CMD_CALL: begin
        pc_d    = jt;
        flush_d = 1'b1;
        push    = 1'b1;
      end
      CMD_RET: begin
        flush_d = 1'b1;
        if (!stack_empty) begin
          pc_d = top_entry;
          pop  = 1'b1;
        end else begin
          // An empty stack falls through to the next instruction.
          pc_d  = cp1;
          unf_d = 1'b1;
        end
      end
      CMD_FOR: begin
        if (take) begin
          pc_d    = reg_target;
          flush_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stack pointer / count / overflow next state
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      // When full, ptr_inc lands on the oldest entry, which then gets overwritten.
      ptr_d = ptr_inc;
      if (stack_full) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      ptr_d   = ptr_dec;
      count_d = count_q - CNT_W'(1);
    end
  end

  // Per-entry write enables
  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push && (ptr_inc == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (wr_sel[i]) begin
          stack_q[i] <= cp1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= WIDTH'(RESET_PC);
      flush_q <= 1'b0;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc_plus_1     = pc_q + WIDTH'(1);
  assign flush         = flush_q;
  assign ras_top       = stack_empty ? '0 : top_entry;
  assign ras_count     = count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: the driver pushes hand-computed expected
// state for each applied vector, and the monitor pops and compares it after
// the clock edge that should produce it.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  cmd;
  logic        take;
  logic [15:0] cmd_pc;
  logic [8:0]  jmp_field;
  logic [5:0]  offset;
  logic [15:0] reg_target;
  logic [15:0] pc_out;
  logic [15:0] pc_plus_1;
  logic        flush;
  logic [15:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  pc_unit_ras dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .cmd          (cmd),
    .take         (take),
    .cmd_pc       (cmd_pc),
    .jmp_field    (jmp_field),
    .offset       (offset),
    .reg_target   (reg_target),
    .pc_out       (pc_out),
    .pc_plus_1    (pc_plus_1),
    .flush        (flush),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] pc;
    logic        fl;
    logic [15:0] top;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string field,
                     input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
    end
  endtask

  // Monitor: compares every expectation that has come due.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %-10s pc=%h flush=%0d top=%h cnt=%0d ovf=%0d unf=%0d",
               e.name, pc_out, flush, ras_top, ras_count, ras_overflow, ras_underflow);
      chk(e.name, "pc_out",    pc_out,               e.pc);
      chk(e.name, "pc_plus_1", pc_plus_1,            e.pc + 16'd1);
      chk(e.name, "flush",     {15'd0, flush},       {15'd0, e.fl});
      chk(e.name, "ras_top",   ras_top,              e.top);
      chk(e.name, "ras_count", {13'd0, ras_count},   {13'd0, e.cnt});
      chk(e.name, "ovf",       {15'd0, ras_overflow},  {15'd0, e.ovf});
      chk(e.name, "unf",       {15'd0, ras_underflow}, {15'd0, e.unf});
    end
  end

  // Apply one vector for one cycle and queue the state expected after the edge.
  task automatic vec(input string nm, input logic r, input logic st,
                     input logic [2:0] c, input logic tk,
                     input logic [15:0] cp, input logic [8:0] jf,
                     input logic [5:0] off, input logic [15:0] rt,
                     input logic [15:0] e_pc, input logic e_fl,
                     input logic [15:0] e_top, input logic [2:0] e_cnt,
                     input logic e_ovf, input logic e_unf);
    exp_t e;
    rst = r; stall = st; cmd = c; take = tk;
    cmd_pc = cp; jmp_field = jf; offset = off; reg_target = rt;
    e.due = cyc + 1; e.pc = e_pc; e.fl = e_fl; e.top = e_top; e.cnt = e_cnt;
    e.ovf = e_ovf; e.unf = e_unf; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, FOR = 3'd5;

  initial begin
    rst = 1'b1; stall = 1'b0; cmd = SEQ; take = 1'b0;
    cmd_pc = '0; jmp_field = '0; offset = '0; reg_target = '0;
    @(posedge clk);
    #1;
    //   name         rst st cmd  tk cmd_pc    jf      off    rt        pc        fl top       cnt ovf unf
    vec("reset0",     1, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vec("reset1",     1, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vec("seq1",       0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0001, 0, 16'h0000, 0, 0, 0);
    vec("seq2",       0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0002, 0, 16'h0000, 0, 0, 0);
    vec("seq3",       0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0003, 0, 16'h0000, 0, 0, 0);
    vec("rst_mid",    1, 0, JMP,  0, 16'h0000, 9'h055, 6'h00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vec("seq_a",      0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0001, 0, 16'h0000, 0, 0, 0);
    vec("branch_t",   0, 0, BR,   1, 16'h0010, 9'h000, 6'h3E, 16'h0000, 16'h000E, 1, 16'h0000, 0, 0, 0);
    vec("branch_nt",  0, 1, BR,   0, 16'h0010, 9'h000, 6'h3E, 16'h0000, 16'h000E, 0, 16'h0000, 0, 0, 0);
    vec("seq_stall",  0, 1, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h000E, 0, 16'h0000, 0, 0, 0);
    vec("call",       0, 0, CALL, 0, 16'h1234, 9'h045, 6'h00, 16'h0000, 16'h1245, 1, 16'h1235, 1, 0, 0);
    vec("ret",        0, 0, RET,  0, 16'h1245, 9'h000, 6'h00, 16'h0000, 16'h1235, 1, 16'h0000, 0, 0, 0);
    vec("seq_b",      0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h1236, 0, 16'h0000, 0, 0, 0);
    vec("call10",     0, 0, CALL, 0, 16'd10,   9'h100, 6'h00, 16'h0000, 16'h0100, 1, 16'd11,    1, 0, 0);
    vec("call20",     0, 0, CALL, 0, 16'd20,   9'h100, 6'h00, 16'h0000, 16'h0100, 1, 16'd21,    2, 0, 0);
    vec("call30",     0, 0, CALL, 0, 16'd30,   9'h100, 6'h00, 16'h0000, 16'h0100, 1, 16'd31,    3, 0, 0);
    vec("call40",     0, 1, CALL, 0, 16'd40,   9'h100, 6'h00, 16'h0000, 16'h0100, 1, 16'd41,    4, 0, 0);
    vec("call50",     0, 0, CALL, 0, 16'd50,   9'h100, 6'h00, 16'h0000, 16'h0100, 1, 16'd51,    4, 1, 0);
    vec("ret1",       0, 0, RET,  0, 16'h0200, 9'h000, 6'h00, 16'h0000, 16'd51,   1, 16'd41,    3, 1, 0);
    vec("ret2",       0, 0, RET,  0, 16'h0200, 9'h000, 6'h00, 16'h0000, 16'd41,   1, 16'd31,    2, 1, 0);
    vec("ret3",       0, 0, RET,  0, 16'h0200, 9'h000, 6'h00, 16'h0000, 16'd31,   1, 16'd21,    1, 1, 0);
    vec("ret4",       0, 0, RET,  0, 16'h0200, 9'h000, 6'h00, 16'h0000, 16'd21,   1, 16'h0000, 0, 1, 0);
    vec("ret_empty",  0, 0, RET,  0, 16'h0300, 9'h000, 6'h00, 16'h0000, 16'h0301, 1, 16'h0000, 0, 1, 1);
    vec("seq_c",      0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0302, 0, 16'h0000, 0, 1, 1);
    vec("for_stall",  0, 1, FOR,  1, 16'h0000, 9'h000, 6'h00, 16'h0100, 16'h0100, 1, 16'h0000, 0, 1, 1);
    vec("for_nt",     0, 0, FOR,  0, 16'h0000, 9'h000, 6'h00, 16'h0100, 16'h0101, 0, 16'h0000, 0, 1, 1);
    vec("jmp_top",    0, 0, JMP,  0, 16'hFFF0, 9'h1FF, 6'h00, 16'h0000, 16'hFFFF, 1, 16'h0000, 0, 1, 1);
    vec("wrap",       0, 0, SEQ,  0, 16'h0000, 9'h000, 6'h00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 1);
    vec("code7",      0, 0, 3'd7, 1, 16'h0040, 9'h0AA, 6'h01, 16'h0055, 16'h0001, 0, 16'h0000, 0, 1, 1);
    vec("reset_end",  1, 0, CALL, 0, 16'h0040, 9'h0AA, 6'h00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0);

    rst = 1'b0; cmd = SEQ; stall = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
